mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port arbiter sharing the single 256-bit off-chip data memory interface between instruction cache (port 0) and data cache (port 1).
- Sits between the CPU top-level cache controllers and Data_Memory.
- Latches the winner's request and holds the memory request stable until mem_ack_i.
- Returns the ack/data to the owner only, then forces one idle cycle before the next grant.

Parameters:
- ADDR_W, 32, address width of ports and memory.
- LINE_W, 256, cache line / memory data width.
- FIXED_PRIO, 0, 0 = round-robin on contention; 1 = port 1 (dcache) always wins.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- p0_enable_i  in  1  port 0 request; held high until p0_ack_o.
- p0_write_i  in  1  port 0 write (1) / read (0).
- p0_addr_i  in  ADDR_W  port 0 line address.
- p0_data_i  in  LINE_W  port 0 write data.
- p0_data_o  out  LINE_W  read data; valid only while p0_ack_o=1.
- p0_ack_o  out  1  one-cycle completion pulse for port 0.
- p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_data_o, p1_ack_o: same as port 0, for port 1.
- mem_data_i  in  LINE_W  memory read data.
- mem_ack_i  in  1  memory completion pulse.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  memory write.
- mem_addr_o  out  ADDR_W  memory address.
- mem_data_o  out  LINE_W  memory write data.

Behaviour:
- Clock is clk_i; reset is rst_i, synchronous and active-high. All state updates on posedge clk_i.
- FSM states: IDLE, GRANT, RELEASE. Registers: owner (1 bit), last_owner (1 bit), latched write/addr/data.
- Reset:
  - state=IDLE, owner=0, last_owner=1 (so port 0 wins the first contention).
  - Latched write/addr/data = 0; mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
  - p0_ack_o=0, p1_ack_o=0.
- IDLE:
  - No request: stay IDLE.
  - Exactly one enable high: owner=that port; latch its write/addr/data; go to GRANT.
  - Both high, FIXED_PRIO=0: owner = ~last_owner.
  - Both high, FIXED_PRIO=1: owner=1.
- GRANT:
  - mem_enable_o=1; mem_write_o/mem_addr_o/mem_data_o driven from latched registers, so they are stable for the whole transaction.
  - Latency: request sampled at edge k, mem_enable_o=1 from edge k+1.
  - Owner's inputs are ignored after latching.
  - On mem_ack_i=1: the owner's ack_o=1 in the same cycle (combinational from mem_ack_i and state/owner). Then last_owner=owner and the FSM goes to RELEASE.
- RELEASE:
  - Exactly one cycle with mem_enable_o=0; all requests ignored; then IDLE.
  - Guarantees memory sees enable low and the finished requester has dropped enable before re-arbitration.
  - Back-to-back transactions are spaced at least 2 cycles apart (RELEASE + IDLE sample).
- Data return: p0_data_o = p1_data_o = mem_data_i (broadcast). Validity is qualified only by the respective ack_o.
- ack_o outputs:
  - Never high outside GRANT.
  - Never high for the non-owner.
  - mem_ack_i in IDLE/RELEASE is ignored.
- mem_write_o, mem_addr_o, mem_data_o hold last latched values outside GRANT; only mem_enable_o is meaningful.
- Requester dropping enable mid-GRANT (protocol violation): transaction still completes and ack pulses; no abort.
- Reset mid-GRANT: immediate IDLE next edge, mem_enable_o=0, no ack for the aborted transaction; last_owner reset to 1.
- Starvation bound, FIXED_PRIO=0: a waiting port is granted after at most one transaction of the other port.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined: adds outputs p0_grants_o[31:0], p1_grants_o[31:0], wait_cycles_o[31:0].
  - Each grants counter increments on entry to GRANT for its port.
  - wait_cycles_o increments every cycle in which a port's enable is high and that port is not the GRANT owner.
  - The wait_cycles_o rule includes IDLE-sample and RELEASE cycles. It increments by 1 even if both ports wait.
  - All counters saturate at 32'hFFFFFFFF and reset to 0 on rst_i.
- Undefined: ports and counters absent; functional behaviour identical.

Test Plan:
- Reset, then single p0 read addr=32'h0000_0400, memory ack after 10 cycles with data 256'hA5...: mem_enable_o=1 one cycle after request; mem_addr_o=32'h400, mem_write_o=0 for 10 cycles; p0_ack_o one-cycle pulse with p0_data_o=256'hA5...; p1_ack_o stays 0.
- p0 and p1 request in the same cycle, FIXED_PRIO=0, after reset: p0 served first; one RELEASE cycle, one IDLE cycle, then p1 granted; p1 write data 256'h1234 appears on mem_data_o with mem_write_o=1.
- Same contention with FIXED_PRIO=1: p1 granted first in each of 3 repeated contentions.
- Change p1_addr_i from 32'h800 to 32'hC00 mid-GRANT: mem_addr_o stays 32'h800 until ack.
- Assert rst_i 4 cycles into GRANT: next cycle mem_enable_o=0, state IDLE; a late mem_ack_i produces no ack_o.
- With MEM_ARB_PERF_EN, run the contention scenario once: p0_grants_o=1, p1_grants_o=1, wait_cycles_o equals the p1 wait duration (13 with 10-cycle memory).

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one line-wide memory between icache (p0) and dcache (p1); MEM_ARB_PERF_EN adds perf counters.
// Latency: request sampled at edge k drives mem_enable_o from edge k+1; ack returns combinationally with mem_ack_i.
// Backpressure: requesters hold enable until their ack; one forced RELEASE cycle separates transactions.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int LINE_W     = 256,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [LINE_W-1:0] p0_data_i,
    output logic [LINE_W-1:0] p0_data_o,
    output logic              p0_ack_o,
    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [LINE_W-1:0] p1_data_i,
    output logic [LINE_W-1:0] p1_data_o,
    output logic              p1_ack_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       p0_grants_o,
    output logic [31:0]       p1_grants_o,
    output logic [31:0]       wait_cycles_o
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t state;
    logic   owner;
    logic   last_owner;
    logic   any_req;
    logic   win;

    // Round-robin favours whichever port did not finish last.
    always_comb begin
        any_req = p0_enable_i | p1_enable_i;
        if (p0_enable_i && p1_enable_i) begin
            win = (FIXED_PRIO != 0) ? 1'b1 : ~last_owner;
        end else begin
            win = p1_enable_i;
        end
    end

    // The mem_* request registers double as the latched copy of the winner's request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            owner        <= 1'b0;
            last_owner   <= 1'b1;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state        <= GRANT;
                        owner        <= win;
                        mem_enable_o <= 1'b1;
                        mem_write_o  <= win ? p1_write_i : p0_write_i;
                        mem_addr_o   <= win ? p1_addr_i  : p0_addr_i;
                        mem_data_o   <= win ? p1_data_i  : p0_data_i;
                    end
                end
                GRANT: begin
                    if (mem_ack_i) begin
                        state        <= RELEASE;
                        mem_enable_o <= 1'b0;
                        last_owner   <= owner;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state        <= IDLE;
                    mem_enable_o <= 1'b0;
                end
            endcase
        end
    end

    assign p0_ack_o  = (state == GRANT) && mem_ack_i && !owner;
    assign p1_ack_o  = (state == GRANT) && mem_ack_i &&  owner;
    assign p0_data_o = mem_data_i;
    assign p1_data_o = mem_data_i;

`ifdef MEM_ARB_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // One count per cycle no matter how many ports are stalled.
    logic waiting;
    assign waiting = (p0_enable_i && !((state == GRANT) && !owner)) ||
                     (p1_enable_i && !((state == GRANT) &&  owner));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p0_grants_o   <= 32'd0;
            p1_grants_o   <= 32'd0;
            wait_cycles_o <= 32'd0;
        end else begin
            if ((state == IDLE) && any_req && !win) p0_grants_o <= sat_inc(p0_grants_o);
            if ((state == IDLE) && any_req &&  win) p1_grants_o <= sat_inc(p1_grants_o);
            if (waiting) wait_cycles_o <= sat_inc(wait_cycles_o);
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one round-robin and one fixed-priority instance checked against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst      [2];
    logic          en       [2][2];
    logic          wr       [2][2];
    logic [AW-1:0] addr     [2][2];
    logic [LW-1:0] wdat     [2][2];
    logic [LW-1:0] rdat     [2][2];
    logic          ack      [2][2];
    logic [LW-1:0] mem_rdat [2];
    logic          mem_ack  [2];
    logic          mem_en   [2];
    logic          mem_wr   [2];
    logic [AW-1:0] mem_addr [2];
    logic [LW-1:0] mem_wdat [2];
`ifdef MEM_ARB_PERF_EN
    logic [31:0]   grants   [2][2];
    logic [31:0]   waits    [2];
`endif

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .FIXED_PRIO(0)) u_rr (
        .clk_i(clk), .rst_i(rst[0]),
        .p0_enable_i(en[0][0]), .p0_write_i(wr[0][0]), .p0_addr_i(addr[0][0]), .p0_data_i(wdat[0][0]),
        .p0_data_o(rdat[0][0]), .p0_ack_o(ack[0][0]),
        .p1_enable_i(en[0][1]), .p1_write_i(wr[0][1]), .p1_addr_i(addr[0][1]), .p1_data_i(wdat[0][1]),
        .p1_data_o(rdat[0][1]), .p1_ack_o(ack[0][1]),
        .mem_data_i(mem_rdat[0]), .mem_ack_i(mem_ack[0]), .mem_enable_o(mem_en[0]),
        .mem_write_o(mem_wr[0]), .mem_addr_o(mem_addr[0]), .mem_data_o(mem_wdat[0])
`ifdef MEM_ARB_PERF_EN
        , .p0_grants_o(grants[0][0]), .p1_grants_o(grants[0][1]), .wait_cycles_o(waits[0])
`endif
    );

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .FIXED_PRIO(1)) u_fp (
        .clk_i(clk), .rst_i(rst[1]),
        .p0_enable_i(en[1][0]), .p0_write_i(wr[1][0]), .p0_addr_i(addr[1][0]), .p0_data_i(wdat[1][0]),
        .p0_data_o(rdat[1][0]), .p0_ack_o(ack[1][0]),
        .p1_enable_i(en[1][1]), .p1_write_i(wr[1][1]), .p1_addr_i(addr[1][1]), .p1_data_i(wdat[1][1]),
        .p1_data_o(rdat[1][1]), .p1_ack_o(ack[1][1]),
        .mem_data_i(mem_rdat[1]), .mem_ack_i(mem_ack[1]), .mem_enable_o(mem_en[1]),
        .mem_write_o(mem_wr[1]), .mem_addr_o(mem_addr[1]), .mem_data_o(mem_wdat[1])
`ifdef MEM_ARB_PERF_EN
        , .p0_grants_o(grants[1][0]), .p1_grants_o(grants[1][1]), .wait_cycles_o(waits[1])
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Transaction-level reference: who holds the memory, what was latched, what comes next.
    bit            m_init  [2];
    bit            m_busy  [2];
    bit            m_rel   [2];
    bit            m_last  [2];
    bit            m_owner [2];
    logic          m_lw    [2];
    logic [AW-1:0] m_la    [2];
    logic [LW-1:0] m_ld    [2];
    int            m_g     [2][2];
    int            m_w     [2];

    int            cyc = 0;
    int            grant_cycles [2];
    int            rise_cyc     [2];
    bit            prev_en      [2];
    int            ack_cnt      [2][2];
    int            ack_cyc      [2][2];
    logic [LW-1:0] ack_dat      [2][2];
    bit            ack_seen     [2][2];

    task automatic model_step(input int i);
        bit exp_ack;
        bit p;
        if (m_init[i]) begin
            check($sformatf("d%0d mem_en", i),   LW'(mem_en[i]),   LW'(m_busy[i]));
            check($sformatf("d%0d mem_wr", i),   LW'(mem_wr[i]),   LW'(m_lw[i]));
            check($sformatf("d%0d mem_addr", i), LW'(mem_addr[i]), LW'(m_la[i]));
            check($sformatf("d%0d mem_wdat", i), mem_wdat[i],      m_ld[i]);
            for (int q = 0; q < 2; q++) begin
                exp_ack = m_busy[i] && mem_ack[i] && (int'(m_owner[i]) == q);
                check($sformatf("d%0d p%0d ack", i, q), LW'(ack[i][q]), LW'(exp_ack));
                if (ack[i][q] === 1'b1) check($sformatf("d%0d p%0d rdata", i, q), rdat[i][q], mem_rdat[i]);
            end
`ifdef MEM_ARB_PERF_EN
            check($sformatf("d%0d p0_grants", i), LW'(grants[i][0]), LW'(m_g[i][0]));
            check($sformatf("d%0d p1_grants", i), LW'(grants[i][1]), LW'(m_g[i][1]));
            check($sformatf("d%0d wait_cycles", i), LW'(waits[i]), LW'(m_w[i]));
`endif
        end
        if (mem_en[i] === 1'b1) grant_cycles[i]++;
        if (mem_en[i] === 1'b1 && !prev_en[i]) rise_cyc[i] = cyc;
        prev_en[i] = (mem_en[i] === 1'b1);
        for (int q = 0; q < 2; q++) begin
            if (ack[i][q] === 1'b1) begin
                ack_cnt[i][q]++;
                ack_cyc[i][q] = cyc;
                ack_dat[i][q] = rdat[i][q];
                ack_seen[i][q] = 1'b1;
            end
        end
        if (rst[i]) begin
            m_init[i] = 1'b1; m_busy[i] = 1'b0; m_rel[i] = 1'b0; m_last[i] = 1'b1; m_owner[i] = 1'b0;
            m_lw[i] = 1'b0; m_la[i] = '0; m_ld[i] = '0;
            m_g[i][0] = 0; m_g[i][1] = 0; m_w[i] = 0;
        end else if (m_init[i]) begin
            if ((en[i][0] && !(m_busy[i] && !m_owner[i])) || (en[i][1] && !(m_busy[i] && m_owner[i])))
                m_w[i]++;
            if (m_busy[i]) begin
                if (mem_ack[i]) begin
                    m_busy[i] = 1'b0; m_rel[i] = 1'b1; m_last[i] = m_owner[i];
                end
            end else if (m_rel[i]) begin
                m_rel[i] = 1'b0;
            end else if (en[i][0] || en[i][1]) begin
                if (en[i][0] && en[i][1]) p = (i == 1) ? 1'b1 : !m_last[i];
                else p = en[i][1];
                m_owner[i] = p; m_busy[i] = 1'b1;
                m_lw[i] = wr[i][p]; m_la[i] = addr[i][p]; m_ld[i] = wdat[i][p];
                m_g[i][p]++;
            end
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) model_step(i);
    end

    // Stimulus side: memory responder and requesters, advanced once per clock.
    bit            mem_auto [2];
    bit            lat_rand [2];
    int            lat      [2];
    int            cnt      [2];
    bit            mem_fix  [2];
    logic [LW-1:0] fix_dat;
    bit            rand_req [2];

    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (mem_ack[i]) begin
                mem_ack[i] = 1'b0;
            end else if (mem_auto[i]) begin
                if (mem_en[i]) begin
                    if (cnt[i] < 0) cnt[i] = lat_rand[i] ? int'($urandom_range(0, 5)) : lat[i] - 1;
                    else cnt[i]--;
                    if (cnt[i] == 0) begin
                        mem_ack[i]  = 1'b1;
                        mem_rdat[i] = mem_fix[i] ? fix_dat : rand_line();
                        cnt[i]      = -1;
                    end
                end else if (lat_rand[i] && $urandom_range(0, 7) == 0) begin
                    mem_ack[i]  = 1'b1;
                    mem_rdat[i] = rand_line();
                end
            end
            for (int q = 0; q < 2; q++) begin
                if (en[i][q] && ack_seen[i][q]) begin
                    en[i][q] = 1'b0;
                    ack_seen[i][q] = 1'b0;
                end else if (rand_req[i] && !en[i][q] && $urandom_range(0, 3) == 0) begin
                    en[i][q]   = 1'b1;
                    wr[i][q]   = 1'($urandom_range(0, 1));
                    addr[i][q] = $urandom;
                    wdat[i][q] = rand_line();
                end
            end
        end
    endtask

    task automatic req(input int i, input int q, input logic w, input logic [AW-1:0] a, input logic [LW-1:0] d);
        en[i][q] = 1'b1; wr[i][q] = w; addr[i][q] = a; wdat[i][q] = d;
    endtask

    task automatic wait_done(input int i);
        int n = 0;
        while ((en[i][0] || en[i][1]) && n < 300) begin
            cycle();
            n++;
        end
        check($sformatf("d%0d done_within_bound", i), LW'(n < 300), LW'(1));
        en[i][0] = 1'b0; en[i][1] = 1'b0;
        repeat (2) cycle();
    endtask

    task automatic do_reset(input int i);
        rst[i] = 1'b1;
        cnt[i] = -1;
        cycle();
        cycle();
        rst[i] = 1'b0;
    endtask

    int g0, a00, a01;

    initial begin
        fix_dat = {32{8'hA5}};
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; mem_ack[i] = 1'b0; mem_rdat[i] = '0;
            mem_auto[i] = 1'b1; lat_rand[i] = 1'b0; lat[i] = 10; cnt[i] = -1;
            mem_fix[i] = 1'b0; rand_req[i] = 1'b0; rise_cyc[i] = 0; grant_cycles[i] = 0;
            for (int q = 0; q < 2; q++) begin
                en[i][q] = 1'b0; wr[i][q] = 1'b0; addr[i][q] = '0; wdat[i][q] = '0;
                ack_cnt[i][q] = 0; ack_cyc[i][q] = 0;
            end
        end
        cycle();
        cycle();
        rst[0] = 1'b0; rst[1] = 1'b0;
        cycle();
        check("rst mem_en", LW'(mem_en[0]), LW'(0));
        check("rst mem_addr", LW'(mem_addr[0]), LW'(0));
        check("rst p1_ack", LW'(ack[1][1]), LW'(0));

        // Single read with a 10-cycle memory.
        mem_fix[0] = 1'b1;
        g0 = grant_cycles[0]; a00 = ack_cnt[0][0]; a01 = ack_cnt[0][1];
        req(0, 0, 1'b0, 32'h0000_0400, '0);
        cycle();
        check("read enable_next_cycle", LW'(mem_en[0]), LW'(1));
        wait_done(0);
        check("read grant_len", LW'(grant_cycles[0] - g0), LW'(10));
        check("read p0_ack_pulses", LW'(ack_cnt[0][0] - a00), LW'(1));
        check("read p1_ack_pulses", LW'(ack_cnt[0][1] - a01), LW'(0));
        check("read p0_data", ack_dat[0][0], fix_dat);
        mem_fix[0] = 1'b0;

        // Contention straight after reset: p0 first, then p1 write three cycles after p0's ack.
        do_reset(0);
        req(0, 0, 1'b0, 32'h0000_1000, '0);
        req(0, 1, 1'b1, 32'h0000_2000, 256'h1234);
        wait_done(0);
        check("rr p0_first", LW'(ack_cyc[0][0] < ack_cyc[0][1]), LW'(1));
        check("rr p1_grant_gap", LW'(rise_cyc[0] - ack_cyc[0][0]), LW'(3));
        check("rr p1_ack_gap", LW'(ack_cyc[0][1] - ack_cyc[0][0]), LW'(12));
        check("rr p1_wdata", mem_wdat[0], 256'h1234);
        check("rr p1_write", LW'(mem_wr[0]), LW'(1));
`ifdef MEM_ARB_PERF_EN
        check("perf p0_grants", LW'(grants[0][0]), LW'(1));
        check("perf p1_grants", LW'(grants[0][1]), LW'(1));
        check("perf wait_cycles", LW'(waits[0]), LW'(13));
`endif

        // Address change while granted must not reach memory.
        req(0, 1, 1'b0, 32'h0000_0800, '0);
        repeat (4) cycle();
        addr[0][1] = 32'h0000_0C00;
        wait_done(0);
        check("hold mem_addr", LW'(mem_addr[0]), LW'(32'h800));

        // Leave last_owner at p0, then abort a p0 transaction with reset.
        req(0, 0, 1'b0, 32'h0000_5000, '0);
        wait_done(0);
        mem_auto[0] = 1'b0;
        req(0, 0, 1'b0, 32'h0000_3000, '0);
        repeat (5) cycle();
        check("abort in_grant", LW'(mem_en[0]), LW'(1));
        a00 = ack_cnt[0][0];
        rst[0] = 1'b1;
        en[0][0] = 1'b0;
        cycle();
        rst[0] = 1'b0;
        check("abort enable_low", LW'(mem_en[0]), LW'(0));
        mem_ack[0] = 1'b1;
        mem_rdat[0] = rand_line();
        #1;
        check("abort late_ack", LW'(ack[0][0]), LW'(0));
        repeat (2) cycle();
        check("abort no_ack_pulse", LW'(ack_cnt[0][0] - a00), LW'(0));
        mem_auto[0] = 1'b1;
        cnt[0] = -1;
        req(0, 0, 1'b0, 32'h0000_6000, '0);
        req(0, 1, 1'b0, 32'h0000_7000, '0);
        wait_done(0);
        check("abort p0_first_after_rst", LW'(ack_cyc[0][0] < ack_cyc[0][1]), LW'(1));

        // Fixed priority: p1 wins every contention.
        for (int k = 0; k < 3; k++) begin
            req(1, 0, 1'b0, 32'h100 + AW'(k), '0);
            req(1, 1, 1'b1, 32'h200 + AW'(k), rand_line());
            wait_done(1);
            check($sformatf("fp p1_first_%0d", k), LW'(ack_cyc[1][1] < ack_cyc[1][0]), LW'(1));
        end

        // Random traffic with random latency and stray acks outside GRANT.
        for (int i = 0; i < 2; i++) begin
            lat_rand[i] = 1'b1;
            rand_req[i] = 1'b1;
        end
        repeat (3000) cycle();
        rand_req[0] = 1'b0; rand_req[1] = 1'b0;
        wait_done(0);
        wait_done(1);
        check("rand d0_grants_seen", LW'(ack_cnt[0][0] > 20 && ack_cnt[0][1] > 20), LW'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
